// File: rtl/id_ex_skid_pkg.sv
// Shared constants and types for the id/ex pipeline register.
package id_ex_skid_pkg;

  localparam int unsigned INST_W     = 32;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [INST_W-1:0] INST_NOP  = 32'h0000_0013;
  localparam logic [DATA_W-1:0] ZERO_WORD = 32'h0000_0000;

  // 32+32+32+32+5+1 = 134
  localparam int unsigned PAYLOAD_W = INST_W + ADDR_W + 2 * DATA_W + REG_ADDR_W + 1;

  // Decoded bundle; inst is the MSB field
  typedef struct packed {
    logic [INST_W-1:0]     inst;
    logic [ADDR_W-1:0]     inst_addr;
    logic [DATA_W-1:0]     op1;
    logic [DATA_W-1:0]     op2;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  reg_wen;
  } id_ex_payload_t;

  // Encoded as {main_valid, skid_valid}; 2'b01 is unreachable
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b10,
    SKID_FULL  = 2'b11
  } skid_state_e;

endpackage

// File: rtl/id_ex_skid_pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with flush. The main entry drives
// out_data; it is reloaded with IDLE whenever it holds nothing, so the
// output bundle stays a plain register output.
module pipe_skid_buf
  import id_ex_skid_pkg::*;
#(
  parameter int unsigned   W    = 8,
  parameter logic [W-1:0]  IDLE = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  input  logic         flush
);

  skid_state_e  r_state;
  skid_state_e  w_state_nxt;
  logic [W-1:0] r_main;
  logic [W-1:0] w_main_nxt;
  logic [W-1:0] r_skid;
  logic [W-1:0] w_skid_nxt;
  logic         r_in_ready;
  logic         w_acc;
  logic         w_deq;

  assign w_acc = in_valid & r_in_ready;
  assign w_deq = r_state[1] & out_ready;

  // Next state and entry loads; flush beats every handshake event
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = SKID_EMPTY;
      w_main_nxt  = IDLE;
    end else begin
      case (r_state)
        SKID_EMPTY: begin
          if (w_acc) begin
            w_main_nxt  = in_data;
            w_state_nxt = SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (w_deq && w_acc) begin
            w_main_nxt = in_data;
          end else if (w_deq) begin
            w_main_nxt  = IDLE;
            w_state_nxt = SKID_EMPTY;
          end else if (w_acc) begin
            w_skid_nxt  = in_data;
            w_state_nxt = SKID_FULL;
          end
        end
        SKID_FULL: begin
          if (w_deq) begin
            w_main_nxt  = r_skid;
            w_state_nxt = SKID_ONE;
          end
        end
        default: begin
          w_main_nxt  = IDLE;
          w_state_nxt = SKID_EMPTY;
        end
      endcase
    end
  end

  // State, entries and the registered ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= SKID_EMPTY;
      r_main     <= IDLE;
      r_skid     <= '0;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_main     <= w_main_nxt;
      r_skid     <= w_skid_nxt;
      r_in_ready <= ~w_state_nxt[0];
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_state[1];
  assign out_data  = r_main;

endmodule

// File: rtl/id_ex_skid.sv
// id -> ex pipeline register built on a 2-entry skid buffer. Presents a NOP
// bundle whenever no valid instruction is held.
// Optional: define ID_EX_STALL_CNT_EN to add the saturating stall_cnt output.
module id_ex_skid
  import id_ex_skid_pkg::*;
#(
  parameter logic [INST_W-1:0] NOP_INST = INST_NOP,
  parameter int unsigned       CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INST_W-1:0]     inst_i,
  input  logic [ADDR_W-1:0]     inst_addr_i,
  input  logic [DATA_W-1:0]     op1_i,
  input  logic [DATA_W-1:0]     op2_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic                  reg_wen_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INST_W-1:0]     inst_o,
  output logic [ADDR_W-1:0]     inst_addr_o,
  output logic [DATA_W-1:0]     op1_o,
  output logic [DATA_W-1:0]     op2_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic                  reg_wen_o,
  input  logic                  flush
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt
`endif
);

  // Bubble held in the main entry while it is invalid
  localparam logic [PAYLOAD_W-1:0] IDLE_PL =
    {NOP_INST, ZERO_WORD, ZERO_WORD, ZERO_WORD, REG_ADDR_W'(0), 1'b0};

  id_ex_payload_t w_in_pl;
  id_ex_payload_t w_out_pl;
  logic           w_out_valid;

  // Pack the decoded bundle
  always_comb begin
    w_in_pl.inst      = inst_i;
    w_in_pl.inst_addr = inst_addr_i;
    w_in_pl.op1       = op1_i;
    w_in_pl.op2       = op2_i;
    w_in_pl.rd_addr   = rd_addr_i;
    w_in_pl.reg_wen   = reg_wen_i;
  end

  pipe_skid_buf #(
    .W    (PAYLOAD_W),
    .IDLE (IDLE_PL)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in_pl),
    .out_valid (w_out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_pl),
    .flush     (flush)
  );

  assign out_valid   = w_out_valid;
  assign inst_o      = w_out_pl.inst;
  assign inst_addr_o = w_out_pl.inst_addr;
  assign op1_o       = w_out_pl.op1;
  assign op2_o       = w_out_pl.op2;
  assign rd_addr_o   = w_out_pl.rd_addr;
  assign reg_wen_o   = w_out_pl.reg_wen;

`ifdef ID_EX_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Saturating count of cycles where ex holds off a valid instruction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_id_ex_skid.sv
// Bench for id_ex_skid: directed table, hand-written corner sequences and a
// randomized run against a queue-based reference model.
module tb_id_ex_skid;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADDI = 32'h0050_0093;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        wen;
  } pl_t;

  typedef struct {
    logic        iv;
    logic        orr;
    logic        fl;
    logic [31:0] addr;
    logic        ev;
    logic        er;
    logic [31:0] eaddr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] inst_i, inst_addr_i, op1_i, op2_i;
  logic [4:0]  rd_addr_i;
  logic        reg_wen_i;
  logic        out_valid, out_ready;
  logic [31:0] inst_o, inst_addr_o, op1_o, op2_o;
  logic [4:0]  rd_addr_o;
  logic        reg_wen_o;
  logic        flush;
`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  pl_t         q[$];
  int unsigned m_stall;

  always #5 clk = ~clk;

  id_ex_skid u_dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .inst_i      (inst_i),
    .inst_addr_i (inst_addr_i),
    .op1_i       (op1_i),
    .op2_i       (op2_i),
    .rd_addr_i   (rd_addr_i),
    .reg_wen_i   (reg_wen_i),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .inst_o      (inst_o),
    .inst_addr_o (inst_addr_o),
    .op1_o       (op1_o),
    .op2_o       (op2_o),
    .rd_addr_o   (rd_addr_o),
    .reg_wen_o   (reg_wen_o),
    .flush       (flush)
`ifdef ID_EX_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic orr, input logic fl, input pl_t p);
    in_valid    = iv;
    out_ready   = orr;
    flush       = fl;
    inst_i      = p.inst;
    inst_addr_i = p.addr;
    op1_i       = p.op1;
    op2_i       = p.op2;
    rd_addr_i   = p.rd;
    reg_wen_i   = p.wen;
  endtask

  function automatic pl_t mk_addi(input logic [31:0] addr);
    pl_t p;
    p.inst = ADDI;
    p.addr = addr;
    p.op1  = addr + 32'd100;
    p.op2  = ~addr;
    p.rd   = 5'd1;
    p.wen  = 1'b1;
    return p;
  endfunction

  function automatic pl_t cur_in();
    pl_t p;
    p.inst = inst_i;
    p.addr = inst_addr_i;
    p.op1  = op1_i;
    p.op2  = op2_i;
    p.rd   = rd_addr_i;
    p.wen  = reg_wen_i;
    return p;
  endfunction

  task automatic model_reset();
    q.delete();
    m_stall = 0;
  endtask

  // Reference: an order-preserving FIFO of depth 2, in_ready while not full
  task automatic model_step();
    bit acc, deq;
    acc = in_valid && (q.size() < 2);
    deq = (q.size() > 0) && out_ready;
    if ((q.size() > 0) && !out_ready && (m_stall != 32'hFFFF_FFFF)) m_stall++;
    if (flush) begin
      q.delete();
    end else begin
      if (deq) void'(q.pop_front());
      if (acc) q.push_back(cur_in());
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    pl_t e;
    bit  v;
    v = (q.size() > 0);
    if (v) e = q[0];
    else begin
      e = '0;
      e.inst = NOP;
    end
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".in_ready"},  32'(in_ready), 32'(q.size() < 2));
    chk({tag, ".inst"},      inst_o, e.inst);
    chk({tag, ".addr"},      inst_addr_o, e.addr);
    chk({tag, ".op1"},       op1_o, e.op1);
    chk({tag, ".op2"},       op2_o, e.op2);
    chk({tag, ".rd"},        32'(rd_addr_o), 32'(e.rd));
    chk({tag, ".wen"},       32'(reg_wen_o), 32'(e.wen));
`ifdef ID_EX_STALL_CNT_EN
    chk({tag, ".stall_cnt"}, stall_cnt, m_stall);
`endif
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  vec_t tbl[12];

  initial begin
    // in valid, out_ready, flush, addr -> exp out_valid, in_ready, addr
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'h00};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h04, 1'b1, 1'b1, 32'h04};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h08, 1'b1, 1'b1, 32'h08};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 32'h00};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 1'b1, 32'h10};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h14, 1'b1, 1'b0, 32'h10};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'h14};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 32'h00};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h20, 1'b1, 1'b1, 32'h20};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h24, 1'b1, 1'b0, 32'h20};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 32'h18, 1'b0, 1'b1, 32'h00};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 32'h00};

    reset_dut();
    chk("reset.in_ready",  32'(in_ready), 32'd1);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.inst",      inst_o, NOP);
    chk("reset.reg_wen",   32'(reg_wen_o), 32'd0);
    chk("reset.addr",      inst_addr_o, 32'd0);

    // Directed table: streaming, backpressure, flush while FULL
    for (int i = 0; i < 12; i++) begin
      logic [31:0] eop1;
      drive(tbl[i].iv, tbl[i].orr, tbl[i].fl, mk_addi(tbl[i].addr));
      tick();
      eop1 = tbl[i].ev ? tbl[i].eaddr + 32'd100 : 32'd0;
      chk($sformatf("tbl%0d.out_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d.in_ready", i),  32'(in_ready), 32'(tbl[i].er));
      chk($sformatf("tbl%0d.inst", i),      inst_o, tbl[i].ev ? ADDI : NOP);
      chk($sformatf("tbl%0d.addr", i),      inst_addr_o, tbl[i].eaddr);
      chk($sformatf("tbl%0d.op1", i),       op1_o, eop1);
      chk($sformatf("tbl%0d.wen", i),       32'(reg_wen_o), 32'(tbl[i].ev));
    end

    // Async reset mid-cycle while one instruction is held
    reset_dut();
    drive(1'b1, 1'b0, 1'b0, mk_addi(32'h30));
    tick();
    chk("areset.pre_valid", 32'(out_valid), 32'd1);
    drive(1'b0, 1'b0, 1'b0, '0);
    #3;
    rst = 1'b0;
    #1;
    chk("areset.out_valid", 32'(out_valid), 32'd0);
    chk("areset.inst",      inst_o, NOP);
    chk("areset.in_ready",  32'(in_ready), 32'd1);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, mk_addi(32'h40));
    tick();
    check_model("areset.resume");
    chk("areset.resume_addr", inst_addr_o, 32'h40);

`ifdef ID_EX_STALL_CNT_EN
    // Five stalled cycles, then a flush that also consumes the instruction
    reset_dut();
    drive(1'b1, 1'b0, 1'b0, mk_addi(32'h50));
    tick();
    drive(1'b0, 1'b0, 1'b0, '0);
    repeat (5) tick();
    chk("stall.five", stall_cnt, 32'd5);
    drive(1'b0, 1'b1, 1'b1, '0);
    tick();
    chk("stall.after_flush", stall_cnt, 32'd5);
    chk("stall.flush_valid", 32'(out_valid), 32'd0);
`endif

    // Randomized run against the FIFO model
    reset_dut();
    for (int n = 0; n < 500; n++) begin
      pl_t p;
      p.inst = $urandom;
      p.addr = $urandom;
      p.op1  = $urandom;
      p.op2  = $urandom;
      p.rd   = 5'($urandom_range(0, 31));
      p.wen  = 1'($urandom_range(0, 1));
      drive(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 16) == 0, p);
      tick();
      check_model($sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
